frame_sequencer: RTL

//  Top-level frame scheduler for the sand simulation.

---
 rtl/frame_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: start the cell engine, copy RAM to VRAM with an optional
// clear behind the copy, then hold for a programmable period while drawing is allowed.
module frame_sequencer #(
    parameter int unsigned COLUMNS    = 640,
    parameter int unsigned ROWS       = 480,
    parameter int unsigned ADDR_WIDTH = $clog2(COLUMNS * ROWS),
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned TICK_WIDTH = 27
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  run_i,
    input  logic                  step_i,
    input  logic                  clear_en_i,
    input  logic [TICK_WIDTH-1:0] period_i,
    input  logic                  draw_en_i,
    output logic                  sim_start_o,
    input  logic                  sim_done_i,
    output logic                  owns_mem_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
    output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
    output logic [DATA_WIDTH-1:0] vram_wr_data_o,
    output logic                  vram_wr_en_o,
    output logic                  draw_en_o,
    output logic [15:0]           frame_count_o,
    output logic                  busy_o
);

    localparam int unsigned N_CELLS = COLUMNS * ROWS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_CELLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SIMULATE,
        COPY,
        DRAIN,
        WAIT
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [RD_LATENCY-1:0]   pipe_valid;
    logic [ADDR_WIDTH-1:0]   pipe_addr [RD_LATENCY];
    logic                    clear_latched;
    logic [TICK_WIDTH-1:0]   tick;
    logic [15:0]             frame_count;
    logic                    sim_start;

    // Read address and valid travel together; index 0 is the tail that lines up with read data.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= IDLE;
            rd_addr       <= '0;
            pipe_valid    <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_addr[i] <= '0;
            end
            clear_latched <= 1'b0;
            tick          <= '0;
            frame_count   <= '0;
            sim_start     <= 1'b0;
        end else begin
            sim_start <= 1'b0;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i-1] <= pipe_valid[i];
                pipe_addr[i-1]  <= pipe_addr[i];
            end
            pipe_valid[RD_LATENCY-1] <= (state == COPY);
            pipe_addr[RD_LATENCY-1]  <= rd_addr;

            case (state)
                IDLE: begin
                    if (run_i || step_i) begin
                        sim_start <= 1'b1;
                        state     <= SIMULATE;
                    end
                end
                SIMULATE: begin
                    if (sim_done_i) begin
                        rd_addr       <= '0;
                        clear_latched <= clear_en_i;
                        state         <= COPY;
                    end
                end
                COPY: begin
                    if (rd_addr == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // Leave on the cycle the last valid retires so COPY+DRAIN spans N_CELLS+RD_LATENCY.
                    if ((pipe_valid >> 1) == '0) begin
                        frame_count <= frame_count + 16'd1;
                        tick        <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    tick <= tick + TICK_WIDTH'(1);
                    if (period_i == '0 || tick == period_i - TICK_WIDTH'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sim_start_o       = sim_start;
    assign owns_mem_o        = (state == COPY) || (state == DRAIN);
    assign busy_o            = (state != IDLE);
    assign ram_rd_address_o  = rd_addr;
    assign ram_wr_address_o  = pipe_addr[0];
    assign ram_wr_data_o     = '0;
    assign ram_wr_en_o       = pipe_valid[0] & clear_latched;
    assign vram_wr_address_o = pipe_addr[0];
    assign vram_wr_data_o    = pipe_valid[0] ? ram_rd_data_i : '0;
    assign vram_wr_en_o      = pipe_valid[0];
    assign draw_en_o         = (state == WAIT) & draw_en_i;
    assign frame_count_o     = frame_count;

endmodule
